// File: rtl/lcd_seq_pkg.sv
// Shared types and constants for the LCD command sequencer.
// Optional watchdog build: define LCD_SEQ_WDOG_EN.
package lcd_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LATCH,
      ISSUE,
      GAP,
      WAIT_DONE,
      FINISH
   } state_t;

   // Opcodes understood by the LCD controller; the sequencer forwards them untouched.
   localparam logic [3:0] OP_WRITE_BACK = 4'd0;
   localparam logic [3:0] OP_SHIFT_UP   = 4'd1;
   localparam logic [3:0] OP_SHIFT_DOWN = 4'd2;
   localparam logic [3:0] OP_SHIFT_LEFT = 4'd3;
   localparam logic [3:0] OP_SHIFT_RIGHT = 4'd4;
   localparam logic [3:0] OP_MAX        = 4'd5;
   localparam logic [3:0] OP_MIN        = 4'd6;
   localparam logic [3:0] OP_AVERAGE    = 4'd7;
   localparam logic [3:0] OP_ROT_CCW    = 4'd8;
   localparam logic [3:0] OP_ROT_CW     = 4'd9;
   localparam logic [3:0] OP_MIRROR_X   = 4'd10;
   localparam logic [3:0] OP_MIRROR_Y   = 4'd11;

endpackage

// File: rtl/lcd_seq_wdog.sv
// Watchdog counter for the LCD command sequencer (used only when
// LCD_SEQ_WDOG_EN is defined). Counts enabled cycles, clears on clr,
// flags expiry when the count reaches TIMEOUT_CYC-1 while enabled.
module lcd_seq_wdog #(
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int W = $clog2(TIMEOUT_CYC) + 1;

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: clear has priority over counting.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = en && (cnt_q == W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/lcd_cmd_seq.sv
// LCD command sequencer: fetches N_CMD opcodes from a command ROM and hands
// them one at a time to the LCD controller, then waits for lcd_done.
// Optional watchdog build: define LCD_SEQ_WDOG_EN.
module lcd_cmd_seq
   import lcd_seq_pkg::*;
#(
   parameter int N_CMD       = 46,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       crom_rd,
   output logic [5:0] crom_a,
   input  logic [3:0] crom_q,
   output logic [3:0] cmd,
   output logic       cmd_valid,
   input  logic       lcd_busy,
   input  logic       lcd_done,
   output logic [5:0] cmd_idx,
   output logic       seq_busy,
   output logic       seq_done,
   output logic       err
);

   // Index is one bit wider than the port so N_CMD=64 can be reached without wrapping.
   localparam logic [6:0] LAST_IDX = 7'(N_CMD - 1);

   if (N_CMD < 1 || N_CMD > 64 || TIMEOUT_CYC < 2) begin : g_bad_param
      $error("lcd_cmd_seq: illegal N_CMD or TIMEOUT_CYC");
   end

   state_t     state_q, state_d;
   logic [3:0] cmd_q, cmd_d;
   logic [6:0] idx_q, idx_d;
   logic       err_q, err_d;
   logic       accept;
   logic       wd_expired;

   assign accept = (state_q == ISSUE) && !lcd_busy;

`ifdef LCD_SEQ_WDOG_EN
   logic wd_en;
   logic wd_clr;

   // Watchdog runs while stalled in ISSUE and throughout WAIT_DONE.
   assign wd_en  = ((state_q == ISSUE) && lcd_busy) || (state_q == WAIT_DONE);
   assign wd_clr = !((state_q == ISSUE) || (state_q == WAIT_DONE)) || accept;

   lcd_seq_wdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_wdog (
      .clk     (clk),
      .reset   (reset),
      .clr     (wd_clr),
      .en      (wd_en),
      .expired (wd_expired)
   );
`else
   assign wd_expired = 1'b0;
`endif

   // Next-state, command capture, index and error logic.
   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      idx_d   = idx_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE, FINISH: begin
            if (start) begin
               state_d = FETCH;
               idx_d   = '0;
               err_d   = 1'b0;
            end
         end
         FETCH: begin
            if (lcd_done) begin
               state_d = FINISH;
               err_d   = 1'b1;
            end else begin
               state_d = LATCH;
            end
         end
         LATCH: begin
            if (lcd_done) begin
               state_d = FINISH;
               err_d   = 1'b1;
            end else begin
               cmd_d   = crom_q;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (lcd_done || wd_expired) begin
               state_d = FINISH;
               err_d   = 1'b1;
            end else if (accept) begin
               idx_d   = idx_q + 7'd1;
               state_d = (idx_q == LAST_IDX) ? WAIT_DONE : GAP;
            end
         end
         GAP: begin
            if (lcd_done) begin
               state_d = FINISH;
               err_d   = 1'b1;
            end else begin
               state_d = FETCH;
            end
         end
         WAIT_DONE: begin
            if (lcd_done) begin
               state_d = FINISH;
            end else if (wd_expired) begin
               state_d = FINISH;
               err_d   = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and data registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cmd_q   <= '0;
         idx_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
      end
   end

   assign crom_rd   = (state_q == FETCH);
   assign crom_a    = idx_q[5:0];
   assign cmd       = cmd_q;
   assign cmd_valid = accept;
   assign cmd_idx   = idx_q[5:0];
   assign seq_busy  = (state_q != IDLE) && (state_q != FINISH);
   assign seq_done  = (state_q == FINISH);
   assign err       = err_q;

endmodule

// File: doc/lcd_cmd_seq.md
LCD_CMD_SEQ -- requirements
Module: lcd_cmd_seq

Interface
REQ-001 SHALL have parameter N_CMD, default 46, number of commands to issue (legal 1..64).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1024, watchdog limit in cycles.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse; begins a command sequence.
REQ-006 crom_rd  output  1  command-ROM read strobe.
REQ-007 crom_a  output  6  command-ROM address.
REQ-008 crom_q  input  4  command-ROM data, valid the cycle after crom_rd.
REQ-009 cmd  output  4  command to LCD controller.
REQ-010 cmd_valid  output  1  cmd qualifier.
REQ-011 lcd_busy  input  1  LCD controller busy.
REQ-012 lcd_done  input  1  LCD controller finished (IRAM write-back complete).
REQ-013 cmd_idx  output  6  index of the next command to issue.
REQ-014 seq_busy  output  1  high in any state except IDLE and FINISH.
REQ-015 seq_done  output  1  held high in FINISH.
REQ-016 err  output  1  sticky error flag, cleared by start or reset.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, LATCH, ISSUE, GAP, WAIT_DONE, FINISH.
REQ-018 IDLE: start -> FETCH, cmd_idx=0, err=0; other inputs ignored.
REQ-019 FETCH: crom_rd=1, crom_a=cmd_idx for exactly one cycle -> LATCH.
REQ-020 LATCH: capture crom_q into cmd register -> ISSUE.
REQ-021 ISSUE: cmd_valid = !lcd_busy (combinational); acceptance = rising edge with cmd_valid=1 and lcd_busy=0.
REQ-022 On acceptance: cmd_idx increments; if cmd_idx was N_CMD-1 -> WAIT_DONE, else -> GAP.
REQ-023 GAP: cmd_valid=0 for exactly one cycle (covers registered busy rise) -> FETCH.
REQ-024 cmd SHALL stay stable from LATCH until acceptance; cmd_valid never high outside ISSUE.
REQ-025 Best-case issue period: 4 cycles per command (FETCH, LATCH, ISSUE, GAP).
REQ-026 WAIT_DONE: lcd_done=1 -> FINISH with err unchanged.
REQ-027 lcd_done=1 in FETCH/LATCH/ISSUE/GAP (early done) -> err=1, FINISH next cycle.
REQ-028 FINISH: seq_done=1, cmd_valid=0; start -> FETCH with cmd_idx=0, err=0, seq_done=0.
REQ-029 start while seq_busy=1 SHALL be ignored.
REQ-030 cmd_idx SHALL never exceed N_CMD; no wrap-around.

Reset
REQ-031 reset low SHALL force IDLE asynchronously, including mid-sequence.
REQ-032 Reset values: cmd=0, cmd_valid=0, crom_rd=0, crom_a=0, cmd_idx=0, seq_busy=0, seq_done=0, err=0, watchdog=0.

Configuration
REQ-033 Macro LCD_SEQ_WDOG_EN defined: watchdog counts cycles in ISSUE with lcd_busy=1 and in WAIT_DONE; clears on acceptance and on state entry.
REQ-034 With the macro, count reaching TIMEOUT_CYC-1 SHALL set err=1 and go to FINISH next cycle.
REQ-035 Without the macro: no counter logic; ISSUE and WAIT_DONE wait indefinitely; err only from early done.

Structure
REQ-036 Package lcd_seq_pkg SHALL hold the state enum and the 4-bit opcode constants (0 write-back, 1-4 shift up/down/left/right, 5 max, 6 min, 7 average, 8 rotate CCW, 9 rotate CW, 10 mirror X, 11 mirror Y).
REQ-037 Watchdog SHALL be sub-module lcd_seq_wdog, instantiated only under LCD_SEQ_WDOG_EN.
REQ-038 Opcode content is not interpreted; all 16 values are passed through unchanged.

Verification
REQ-039 N_CMD=3, ROM={1,5,0}, lcd_busy=0 throughout -> cmd 1,5,0 accepted at cycles 4,8,12 after start; then lcd_done -> seq_done=1, err=0.
REQ-040 lcd_busy held 1 for 20 cycles in ISSUE -> cmd_valid=0 throughout, cmd stable, acceptance on the first cycle busy=0.
REQ-041 lcd_done pulsed after 2nd of 3 commands -> err=1, seq_done=1, third command never issued.
REQ-042 reset low mid-ISSUE -> all outputs at reset values immediately; start afterwards restarts at crom_a=0.
REQ-043 LCD_SEQ_WDOG_EN, TIMEOUT_CYC=16, lcd_busy stuck 1 -> err=1 and FINISH after 16 ISSUE cycles; without macro, still in ISSUE after 100 cycles.
REQ-044 start pulsed while seq_busy=1 -> no effect on cmd_idx or state.
